ps2_command_tx: RTL and testbench

PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

---
 rtl/pong_pkg.sv | 30 +++
 rtl/ps2_sync_edge.sv | 39 +++
 rtl/ps2_command_tx.sv | 166 ++++++++++++++++
 tb/tb_ps2_command_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, frame constants and
// default timing in 50 MHz clock cycles.
package pong_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 10;

  localparam int unsigned PS2_INHIBIT_DEFAULT = 6000;
  localparam int unsigned PS2_SETUP_DEFAULT   = 100;
  localparam int unsigned PS2_TIMEOUT_DEFAULT = 1000000;

  // Counter width able to hold the largest of the three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock; idle level of both lines is high.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_dat_meta;
  logic r_dat_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_dat_in;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign clk_sync = r_clk_sync;
  assign dat_sync = r_dat_sync;
  assign clk_fall = ~r_clk_sync & r_clk_prev;

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues the
// request-to-send start bit, shifts the byte plus odd parity, checks the ack.
module ps2_command_tx
  import pong_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_DEFAULT,
  parameter int unsigned SETUP_CYCLES   = PS2_SETUP_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] in_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_W =
    cnt_width(INHIBIT_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_to;
  logic [3:0]       r_bit;
  logic [7:0]       r_data;
  logic             r_parity;
  logic             r_dat_oe;
  logic             r_done;
  logic             r_error;

  logic w_clk_sync;
  logic w_dat_sync;
  logic w_fall;
  logic w_timeout;
  logic w_watch;

  ps2_sync_edge u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (w_clk_sync),
    .dat_sync   (w_dat_sync),
    .clk_fall   (w_fall)
  );

  assign w_watch   = (r_state == ST_SEND) || (r_state == ST_ACK) ||
                     (r_state == ST_WAIT_IDLE);
  assign w_timeout = (r_to == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_to     <= '0;
      r_bit    <= '0;
      r_data   <= '0;
      r_parity <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;

      // Device-clock watchdog: restarts on every falling edge, saturates.
      if (w_watch) begin
        if (w_fall)           r_to <= '0;
        else if (r_to != '1)  r_to <= r_to + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_data   <= in_data;
            r_parity <= ~^in_data;
            r_cnt    <= '0;
            r_state  <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_dat_oe <= 1'b1;
            r_state  <= ST_REQ;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_REQ: begin
          if (r_cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_to    <= '0;
            r_state <= ST_SEND;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_SEND: begin
          if (w_timeout) begin
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (w_fall) begin
            r_bit <= r_bit + 1'b1;
            if (r_bit < 4'(PS2_DATA_BITS)) begin
              r_dat_oe <= ~r_data[r_bit[2:0]];
            end else if (r_bit == 4'(PS2_DATA_BITS)) begin
              r_dat_oe <= ~r_parity;
            end else begin
              r_dat_oe <= 1'b0;
              r_state  <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          if (w_timeout) begin
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (w_fall) begin
            if (!w_dat_sync) begin
              r_state <= ST_WAIT_IDLE;
            end else begin
              r_error <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (w_timeout) begin
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (w_clk_sync && w_dat_sync) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_dat_oe <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready    = (r_state == ST_IDLE);
  assign ps2_clk_oe = (r_state == ST_INHIBIT) || (r_state == ST_REQ);
  assign ps2_dat_oe = r_dat_oe;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: a PS/2 device model clocks frames out of the host,
// captured line bits are compared with a frame built from the byte value.
module tb_ps2_command_tx;

  localparam int unsigned INH  = 40;
  localparam int unsigned SET  = 8;
  localparam int unsigned TOUT = 300;
  localparam int          HALF = 10;

  localparam int MODE_ACK   = 0;
  localparam int MODE_NOACK = 1;
  localparam int MODE_STALL = 2;
  localparam int MODE_RESET = 3;

  logic       clock;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] in_data;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       done;
  logic       error;
  logic       dev_clk;
  logic       dev_dat;
  logic       w_clk_line;
  logic       w_dat_line;

  int n_cmp, n_mis;
  int n_done, n_err, n_both, n_acc;
  int cyc, err_cyc;
  bit hold_rand;

  assign w_clk_line = ps2_clk_oe ? 1'b0 : dev_clk;
  assign w_dat_line = ps2_dat_oe ? 1'b0 : dev_dat;

  ps2_command_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .in_data    (in_data),
    .ps2_clk_in (w_clk_line),
    .ps2_dat_in (w_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (reset_n && s_valid && s_ready) n_acc++;
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (done) n_done++;
      if (error) begin n_err++; err_cyc = cyc; end
      if (done && error) n_both++;
    end
    if (hold_rand) in_data = 8'($urandom);
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line image of a frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic run_frame(input logic [7:0] b, input int mode, input int stop_e, input bit hold_v);
    int n_inh, n_req, guard, d0, e0, a0, t_last;
    logic [10:0] got;
    got = '0;
    t_last = 0;
    guard = 0;
    while (!s_ready && guard < 50) begin @(negedge clock); guard++; end
    d0 = n_done; e0 = n_err; a0 = n_acc;
    s_valid = 1'b1;
    in_data = b;
    @(negedge clock);
    if (hold_v) hold_rand = 1'b1; else s_valid = 1'b0;
    check("ready_drop", s_ready, 0);

    n_inh = 0; n_req = 0; guard = 0;
    while (guard < int'(INH + SET) + 50) begin
      if (ps2_clk_oe && !ps2_dat_oe)     n_inh++;
      else if (ps2_clk_oe && ps2_dat_oe) n_req++;
      else break;
      @(negedge clock);
      guard++;
    end
    check("inhibit_len", n_inh, INH);
    check("setup_len", n_req, SET);
    check("start_held", ps2_dat_oe, 1);

    repeat (3) @(negedge clock);
    for (int e = 1; e <= 11; e++) begin
      if (mode == MODE_STALL && e > stop_e) break;
      repeat (HALF) @(negedge clock);
      if (e == 1) got[0] = w_dat_line;
      if (e == 11 && mode == MODE_ACK) begin
        dev_dat = 1'b0;
        repeat (4) @(negedge clock);
      end
      dev_clk = 1'b0;
      t_last = cyc;
      if (mode == MODE_RESET && e == stop_e) begin
        reset_n = 1'b0;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        repeat (3) @(negedge clock);
        dev_clk = 1'b1;
        hold_rand = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_ready", s_ready, 1);
        check("rst_no_pulse", (n_done - d0) + (n_err - e0), 0);
        return;
      end
      repeat (HALF) @(negedge clock);
      if (e <= 10) got[e] = w_dat_line;
      dev_clk = 1'b1;
    end
    repeat (2) @(negedge clock);
    dev_dat = 1'b1;

    guard = 0;
    while (guard < int'(TOUT) + 60) begin
      if (done || error || n_done != d0 || n_err != e0) break;
      @(negedge clock);
      guard++;
    end
    s_valid = 1'b0;
    hold_rand = 1'b0;
    check("pulse_seen", (guard < int'(TOUT) + 60), 1);
    repeat (2) @(negedge clock);

    check("accepts", n_acc - a0, 1);
    check("ready_back", s_ready, 1);
    check("oe_released", {ps2_clk_oe, ps2_dat_oe}, 0);
    if (mode == MODE_ACK) begin
      check("frame", got, frame_of(b));
      check("done_cnt", n_done - d0, 1);
      check("err_cnt", n_err - e0, 0);
    end else if (mode == MODE_NOACK) begin
      check("frame", got, frame_of(b));
      check("done_cnt", n_done - d0, 0);
      check("err_cnt", n_err - e0, 1);
    end else begin
      check("done_cnt", n_done - d0, 0);
      check("err_cnt", n_err - e0, 1);
      // 2 sync flops + 1 cycle to clear the watchdog + TOUT counts + registered pulse
      check("timeout_delay", err_cyc - t_last, TOUT + 4);
    end
  endtask

  initial begin
    logic [7:0] b;
    n_cmp = 0; n_mis = 0; n_done = 0; n_err = 0; n_both = 0; n_acc = 0;
    cyc = 0; err_cyc = 0; hold_rand = 1'b0;
    reset_n = 1'b0; s_valid = 1'b0; in_data = '0; dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_s_ready", s_ready, 1);
    check("rst_clk_oe0", ps2_clk_oe, 0);
    check("rst_dat_oe0", ps2_dat_oe, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_frame(8'hED, MODE_ACK, 0, 1'b0);
    run_frame(8'h00, MODE_NOACK, 0, 1'b0);
    run_frame(8'($urandom), MODE_STALL, 4, 1'b0);
    b = 8'($urandom) & 8'hEF;
    run_frame(b, MODE_RESET, 6, 1'b0);
    run_frame(8'hF4, MODE_ACK, 0, 1'b0);
    run_frame(8'($urandom), MODE_ACK, 0, 1'b1);
    for (int i = 0; i < 5; i++) run_frame(8'($urandom), MODE_ACK, 0, 1'b0);

    check("done_and_error", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
